// File: rtl/sync_driver.sv
// -----------------------------------------------------------------------------
// sync_driver
//
// Initiator side of the compiled-function sync handshake. It accepts one command
// carrying a single argument and presents that argument to a compiled DUT on in0.
// It then waits for out0 and returns one response beat. The beat carries the
// result, the number of cycles spent in the call, and a timeout flag.
//
// Handshake rule used on every channel (cmd, dut in, dut out, rsp): a beat
// transfers on a rising clock edge where valid & ready are both high. Once the
// sender raises valid, it holds valid and its payload stable until the transfer
// happens. The only exception is a timeout abort, which drops dut_in_valid
// without a transfer. After an abort the DUT must be reset before it is used
// again.
//
// Ports
//   clk, nrst       clock (rising edge) and asynchronous active-low reset
//   cmd_valid/ready command channel, cmd_arg is the argument
//   dut_in_valid    to DUT in_valid, dut_in0 carries the latched argument
//   dut_in_ready    from DUT in_ready
//   dut_out_valid   from DUT out_valid, dut_out0 carries the result
//   dut_out_ready   to DUT out_ready
//   rsp_valid/ready response channel: rsp_data, rsp_cycles, rsp_timeout
//   busy            high whenever a call is in progress (state != IDLE)
//   dbg_state       current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
module sync_driver #(
    parameter int N       = 16,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_arg,
    output logic             dut_in_valid,
    input  logic             dut_in_ready,
    output logic [N-1:0]     dut_in0,
    input  logic             dut_out_valid,
    output logic             dut_out_ready,
    input  logic [N-1:0]     dut_out0,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // The comparison is done one bit wider than the counter. This keeps the
    // limit test correct even when TIMEOUT sits just below 2**CNT_W.
    localparam logic [CNT_W:0]   LIMIT_W   = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic              dut_in_valid_q, dut_in_valid_d;
    logic              dut_out_ready_q, dut_out_ready_d;
    logic [N-1:0]      dut_in0_q, dut_in0_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [N-1:0]      rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  rsp_cycles_q, rsp_cycles_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic [CNT_W:0]    cnt_next_w;
    logic              at_limit;
    logic              in_hs;
    logic              out_hs;

    // cnt_next_w is the count including the current cycle. When it reaches
    // TIMEOUT and no handshake moves the call forward, the call is aborted.
    assign cnt_next_w = {1'b0, counter_q} + (CNT_W+1)'(1);
    assign at_limit   = (cnt_next_w >= LIMIT_W);
    assign in_hs      = dut_in_valid_q & dut_in_ready;
    assign out_hs     = dut_out_ready_q & dut_out_valid;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= S_IDLE;
            counter_q       <= '0;
            dut_in_valid_q  <= 1'b0;
            dut_out_ready_q <= 1'b0;
            dut_in0_q       <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_cycles_q    <= '0;
            rsp_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            dut_in_valid_q  <= dut_in_valid_d;
            dut_out_ready_q <= dut_out_ready_d;
            dut_in0_q       <= dut_in0_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_cycles_q    <= rsp_cycles_d;
            rsp_timeout_q   <= rsp_timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // A handshake in the same cycle as the limit takes priority.
                if (in_hs)         state_d = S_WAIT;
                else if (at_limit) state_d = S_RESP;
            end
            S_WAIT: begin
                if (out_hs)        state_d = S_RESP;
                else if (at_limit) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        counter_d       = counter_q;
        dut_in_valid_d  = dut_in_valid_q;
        dut_out_ready_d = dut_out_ready_q;
        dut_in0_d       = dut_in0_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        rsp_cycles_d    = rsp_cycles_q;
        rsp_timeout_d   = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dut_in0_d      = cmd_arg;
                    counter_d      = '0;
                    dut_in_valid_d = 1'b1;
                end
            end
            S_ISSUE, S_WAIT: begin
                // The counter saturates at the limit, so it never wraps.
                if (!at_limit) counter_d = cnt_next_w[CNT_W-1:0];

                if (state_q == S_ISSUE && in_hs) begin
                    dut_in_valid_d  = 1'b0;
                    dut_out_ready_d = 1'b1;
                end else if (state_q == S_WAIT && out_hs) begin
                    rsp_data_d      = dut_out0;
                    rsp_cycles_d    = cnt_next_w[CNT_W-1:0];
                    rsp_timeout_d   = 1'b0;
                    dut_out_ready_d = 1'b0;
                    rsp_valid_d     = 1'b1;
                end else if (at_limit) begin
                    dut_in_valid_d  = 1'b0;
                    dut_out_ready_d = 1'b0;
                    rsp_data_d      = '0;
                    rsp_cycles_d    = TIMEOUT_C;
                    rsp_timeout_d   = 1'b1;
                    rsp_valid_d     = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;
    assign dut_in_valid  = dut_in_valid_q;
    assign dut_out_ready = dut_out_ready_q;
    assign dut_in0       = dut_in0_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_cycles    = rsp_cycles_q;
    assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_sync_driver.sv
// -----------------------------------------------------------------------------
// tb_sync_driver
//
// Drives calls through sync_driver into a configurable stub of the compiled DUT.
// The stub has four settings:
//   - how many cycles in_ready stays low,
//   - the out_valid latency after the in-handshake,
//   - a "never answers" mode,
//   - a fixed result or an xor-keyed echo.
// The expected response for each call is computed by model_call() from
// the call-level timing rules and compared with what the driver returns.
// -----------------------------------------------------------------------------
module tb_sync_driver;

    localparam int N       = 16;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 200;
    localparam int W       = 1 + CNT_W + N;

    logic             clk = 1'b0;
    logic             nrst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [N-1:0]     cmd_arg;
    logic             dut_in_valid;
    logic             dut_in_ready;
    logic [N-1:0]     dut_in0;
    logic             dut_out_valid;
    logic             dut_out_ready;
    logic [N-1:0]     dut_out0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_data;
    logic [CNT_W-1:0] rsp_cycles;
    logic             rsp_timeout;
    logic             busy;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Stub configuration, written by the test tasks.
    int           stub_in_delay;
    int           stub_lat;
    bit           stub_never;
    bit           stub_always_out;
    bit           stub_fixed;
    logic [N-1:0] stub_fixed_val;
    logic [N-1:0] stub_key;

    // Stub state.
    int           in_seen;
    bit           armed;
    int           wcnt;
    logic [N-1:0] cap;

    sync_driver #(.N(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk           (clk),
        .nrst          (nrst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_arg       (cmd_arg),
        .dut_in_valid  (dut_in_valid),
        .dut_in_ready  (dut_in_ready),
        .dut_in0       (dut_in0),
        .dut_out_valid (dut_out_valid),
        .dut_out_ready (dut_out_ready),
        .dut_out0      (dut_out0),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_cycles    (rsp_cycles),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- compiled-DUT stub ----------------
    assign dut_in_ready  = (in_seen >= stub_in_delay);
    assign dut_out_valid = stub_always_out || (armed && !stub_never && (wcnt + 1 >= stub_lat));
    assign dut_out0      = stub_fixed ? stub_fixed_val : (armed ? (cap ^ stub_key) : ~dut_in0);

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            in_seen <= 0;
            armed   <= 1'b0;
            wcnt    <= 0;
            cap     <= '0;
        end else begin
            if (dut_in_valid && !dut_in_ready) in_seen <= in_seen + 1;
            else                               in_seen <= 0;
            if (dut_in_valid && dut_in_ready) begin
                armed <= 1'b1;
                wcnt  <= 0;
                cap   <= dut_in0;
            end else if (armed) begin
                if (dut_out_valid && dut_out_ready) armed <= 1'b0;
                else                                wcnt  <= wcnt + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    // Cycles are counted in ISSUE+WAIT. The in-handshake happens in cycle
    // d_in+1. The result arrives lat cycles after that, so it is taken in
    // cycle d_in+1+lat, provided that cycle is within TIMEOUT.
    function automatic logic [W-1:0] model_call(input logic [N-1:0] arg, input int d_in,
                                                input int lat, input bit never, input bit fixed,
                                                input logic [N-1:0] fval, input logic [N-1:0] key);
        int               t_out;
        logic [N-1:0]     d;
        logic [CNT_W-1:0] c;
        logic             to;
        t_out = d_in + 1 + lat;
        if (never || t_out > TIMEOUT) begin
            d  = '0;
            c  = CNT_W'(TIMEOUT);
            to = 1'b1;
        end else begin
            d  = fixed ? fval : (arg ^ key);
            c  = CNT_W'(t_out);
            to = 1'b0;
        end
        return {to, c, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_stub(input int d_in, input int lat, input bit never, input bit always_out,
                            input bit fixed, input logic [N-1:0] fval, input logic [N-1:0] key);
        stub_in_delay   = d_in;
        stub_lat        = lat;
        stub_never      = never;
        stub_always_out = always_out;
        stub_fixed      = fixed;
        stub_fixed_val  = fval;
        stub_key        = key;
    endtask

    // Runs one call and reports what was observed. The phases are:
    //   1. Issue the command.
    //   2. Count edges after the accept edge until rsp_valid appears; r_lat
    //      holds that count.
    //   3. Hold rsp_ready low for `hold` cycles. If push_cmd is set, cmd_valid
    //      is held high during this window.
    //   4. Consume the response.
    // The flags report:
    //   issue_ok - dut_in0 stayed stable and out_ready stayed low while
    //              in_valid was high, and busy stayed set.
    //   hold_ok  - the response stayed stable, cmd_ready stayed low, and the
    //              driver released correctly.
    task automatic run_call(input logic [N-1:0] arg, input int hold, input bit push_cmd,
                            output logic [N-1:0] r_data, output logic [CNT_W-1:0] r_cycles,
                            output logic r_to, output int r_lat,
                            output bit issue_ok, output bit hold_ok, output bit got_rsp);
        int n;
        issue_ok = 1'b1;
        hold_ok  = 1'b1;
        got_rsp  = 1'b0;
        r_lat    = -1;
        r_data   = '0;
        r_cycles = '0;
        r_to     = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        cmd_valid = 1'b1;
        cmd_arg   = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_arg   = N'($urandom);
        n = 0;
        while (!rsp_valid && n < 2 * TIMEOUT) begin
            if (dut_in_valid && (dut_in0 !== arg || dut_out_ready !== 1'b0)) issue_ok = 1'b0;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) issue_ok = 1'b0;
            @(posedge clk); #1; n++;
        end
        if (rsp_valid !== 1'b1) return;
        got_rsp  = 1'b1;
        r_lat    = n;
        r_data   = rsp_data;
        r_cycles = rsp_cycles;
        r_to     = rsp_timeout;
        cmd_valid = push_cmd;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== r_data || rsp_cycles !== r_cycles ||
                rsp_timeout !== r_to || cmd_ready !== 1'b0) hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        if (cmd_ready !== 1'b0) hold_ok = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) hold_ok = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst = 1'b0;
        #3;
        checks++;
        if ({dut_in_valid, dut_out_ready, rsp_valid, rsp_data, rsp_cycles, rsp_timeout, dut_in0, busy} !== '0) begin
            errors++;
            $display("FAIL reset_values: got in_v=%b out_r=%b rsp_v=%b data=%h cyc=%0d to=%b in0=%h busy=%b, want all 0",
                     dut_in_valid, dut_out_ready, rsp_valid, rsp_data, rsp_cycles, rsp_timeout, dut_in0, busy);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_immediate();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr;
        set_stub(0, 1, 1'b0, 1'b1, 1'b0, '0, '0);
        exp_q.push_back(model_call(16'd8, 0, 1, 1'b0, 1'b0, '0, '0));
        run_call(16'd8, 0, 1'b0, d, c, t, lat, iok, hok, gr);
        exp = exp_q.pop_front();
        checks++;
        if ({gr, t, c, d} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL immediate_rsp: got rsp=%b to=%b cyc=%0d data=%0d, want to=%b cyc=%0d data=%0d",
                     gr, t, c, d, exp[W-1], exp[N +: CNT_W], exp[N-1:0]);
        end
        checks++;
        if (c !== 8'd2 || lat !== 2) begin
            errors++;
            $display("FAIL immediate_min_call: cycles=%0d latency=%0d, want 2/2", c, lat);
        end
        checks++;
        if ({iok, hok} !== 2'b11) begin
            errors++;
            $display("FAIL immediate_protocol: issue_ok=%b hold_ok=%b, want 1/1", iok, hok);
        end
    endtask

    task automatic test_factorial();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr;
        set_stub(0, 5, 1'b0, 1'b0, 1'b1, 16'd40320, '0);
        exp_q.push_back(model_call(16'd8, 0, 5, 1'b0, 1'b1, 16'd40320, '0));
        run_call(16'd8, 0, 1'b0, d, c, t, lat, iok, hok, gr);
        exp = exp_q.pop_front();
        checks++;
        if ({gr, t, c, d} !== {1'b1, exp} || c !== 8'd6 || d !== 16'd40320) begin
            errors++;
            $display("FAIL factorial_rsp: got rsp=%b to=%b cyc=%0d data=%0d, want to=0 cyc=6 data=40320",
                     gr, t, c, d);
        end
        checks++;
        if (lat !== 6 || {iok, hok} !== 2'b11) begin
            errors++;
            $display("FAIL factorial_timing: latency=%0d issue_ok=%b hold_ok=%b, want 6/1/1", lat, iok, hok);
        end
    endtask

    task automatic test_in_stall();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr;
        set_stub(3, 1, 1'b0, 1'b1, 1'b0, '0, '0);
        exp_q.push_back(model_call(16'd8, 3, 1, 1'b0, 1'b0, '0, '0));
        run_call(16'd8, 0, 1'b0, d, c, t, lat, iok, hok, gr);
        exp = exp_q.pop_front();
        checks++;
        if ({gr, t, c, d} !== {1'b1, exp} || c !== 8'd5) begin
            errors++;
            $display("FAIL in_stall_rsp: got rsp=%b to=%b cyc=%0d data=%0d, want to=0 cyc=5 data=8",
                     gr, t, c, d);
        end
        checks++;
        if (iok !== 1'b1) begin
            errors++;
            $display("FAIL in_stall_issue: issue_ok=%b (in0 stable, out_ready low), want 1", iok);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr;
        set_stub(0, 1, 1'b1, 1'b0, 1'b0, '0, '0);
        exp_q.push_back(model_call(16'h00AB, 0, 1, 1'b1, 1'b0, '0, '0));
        run_call(16'h00AB, 0, 1'b0, d, c, t, lat, iok, hok, gr);
        exp = exp_q.pop_front();
        checks++;
        if ({gr, t, c, d} !== {1'b1, exp} || c !== 8'd200 || t !== 1'b1 || d !== '0) begin
            errors++;
            $display("FAIL timeout_rsp: got rsp=%b to=%b cyc=%0d data=%0d, want to=1 cyc=200 data=0",
                     gr, t, c, d);
        end
        checks++;
        if (lat !== TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: rsp_valid %0d cycles after accept, want %0d", lat + 1, TIMEOUT + 1);
        end
    endtask

    // The result arrives in exactly the TIMEOUT-th cycle, so it must win.
    // With one cycle more latency the call must abort instead.
    task automatic test_timeout_boundary();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr;
        for (int k = 0; k < 2; k++) begin
            set_stub(0, TIMEOUT - 1 + k, 1'b0, 1'b0, 1'b0, '0, 16'h5A5A);
            exp_q.push_back(model_call(16'h1357, 0, TIMEOUT - 1 + k, 1'b0, 1'b0, '0, 16'h5A5A));
            run_call(16'h1357, 0, 1'b0, d, c, t, lat, iok, hok, gr);
            exp = exp_q.pop_front();
            checks++;
            if ({gr, t, c, d} !== {1'b1, exp} || lat !== int'(exp[N +: CNT_W])) begin
                errors++;
                $display("FAIL timeout_boundary_%0d: got to=%b cyc=%0d data=%h lat=%0d, want to=%b cyc=%0d data=%h",
                         k, t, c, d, lat, exp[W-1], exp[N +: CNT_W], exp[N-1:0]);
            end
        end
    endtask

    task automatic test_rsp_backpressure();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr;
        set_stub(1, 2, 1'b0, 1'b0, 1'b0, '0, 16'h0F0F);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(model_call(16'h2468 + 16'(k), 1, 2, 1'b0, 1'b0, '0, 16'h0F0F));
            run_call(16'h2468 + 16'(k), 4, 1'b1, d, c, t, lat, iok, hok, gr);
            exp = exp_q.pop_front();
            checks++;
            if ({gr, t, c, d} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL backpressure_rsp_%0d: got to=%b cyc=%0d data=%h, want to=%b cyc=%0d data=%h",
                         k, t, c, d, exp[W-1], exp[N +: CNT_W], exp[N-1:0]);
            end
            checks++;
            if (hok !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: hold_ok=%b (rsp stable, cmd held off), want 1", k, hok);
            end
        end
    endtask

    task automatic test_reset_mid_call();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr; bit saw_rsp;
        set_stub(0, 1, 1'b1, 1'b0, 1'b0, '0, '0);
        cmd_valid = 1'b1;
        cmd_arg   = 16'h1234;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (dut_out_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_call_wait: out_ready=%b busy=%b, want 1/1", dut_out_ready, busy);
        end
        #1 nrst = 1'b0;
        #1;
        checks++;
        if ({dut_in_valid, dut_out_ready, rsp_valid, rsp_data, rsp_cycles, rsp_timeout, dut_in0, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_call_async: in_v=%b out_r=%b rsp_v=%b data=%h cyc=%0d to=%b in0=%h busy=%b, want all 0",
                     dut_in_valid, dut_out_ready, rsp_valid, rsp_data, rsp_cycles, rsp_timeout, dut_in0, busy);
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_call_ready: cmd_ready=%b, want 1", cmd_ready);
        end
        saw_rsp = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        checks++;
        if (saw_rsp !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_call_no_rsp: rsp_valid seen=%b, want 0", saw_rsp);
        end
        set_stub(0, 1, 1'b0, 1'b1, 1'b0, '0, '0);
        exp_q.push_back(model_call(16'd3, 0, 1, 1'b0, 1'b0, '0, '0));
        run_call(16'd3, 0, 1'b0, d, c, t, lat, iok, hok, gr);
        exp = exp_q.pop_front();
        checks++;
        if ({gr, t, c, d} !== {1'b1, exp} || d !== 16'd3) begin
            errors++;
            $display("FAIL reset_mid_call_next: got to=%b cyc=%0d data=%0d, want to=0 cyc=2 data=3", t, c, d);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr;
        logic [N-1:0] arg, key;
        int d_in, l, hold;
        for (int k = 0; k < 30; k++) begin
            arg  = N'($urandom);
            key  = N'($urandom);
            d_in = $urandom_range(0, 4);
            l    = $urandom_range(1, 8);
            hold = $urandom_range(0, 3);
            set_stub(d_in, l, 1'b0, 1'b0, 1'b0, '0, key);
            exp_q.push_back(model_call(arg, d_in, l, 1'b0, 1'b0, '0, key));
            run_call(arg, hold, 1'($urandom_range(0, 1)), d, c, t, lat, iok, hok, gr);
            exp = exp_q.pop_front();
            checks++;
            if ({gr, t, c, d} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL random_rsp_%0d: got rsp=%b to=%b cyc=%0d data=%h, want to=%b cyc=%0d data=%h",
                         k, gr, t, c, d, exp[W-1], exp[N +: CNT_W], exp[N-1:0]);
            end
            checks++;
            if (lat !== int'(exp[N +: CNT_W])) begin
                errors++;
                $display("FAIL random_latency_%0d: latency=%0d, want %0d", k, lat, exp[N +: CNT_W]);
            end
            checks++;
            if ({iok, hok} !== 2'b11) begin
                errors++;
                $display("FAIL random_protocol_%0d: issue_ok=%b hold_ok=%b, want 1/1", k, iok, hok);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp; logic [N-1:0] d; logic [CNT_W-1:0] c; logic t;
        int lat; bit iok, hok, gr;
        logic [N-1:0] arg;
        set_stub(0, 1, 1'b0, 1'b1, 1'b0, '0, 16'hC3C3);
        for (int k = 0; k < 5; k++) begin
            arg = N'($urandom);
            exp_q.push_back(model_call(arg, 0, 1, 1'b0, 1'b0, '0, 16'hC3C3));
            run_call(arg, 0, 1'b0, d, c, t, lat, iok, hok, gr);
            exp = exp_q.pop_front();
            checks++;
            if ({gr, t, c, d} !== {1'b1, exp} || lat !== 2 || {iok, hok} !== 2'b11) begin
                errors++;
                $display("FAIL back_to_back_%0d: got to=%b cyc=%0d data=%h lat=%0d ok=%b%b, want to=0 cyc=2 data=%h lat=2 ok=11",
                         k, t, c, d, lat, iok, hok, exp[N-1:0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        nrst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_arg   = '0;
        rsp_ready = 1'b0;
        set_stub(0, 1, 1'b0, 1'b0, 1'b0, '0, '0);

        test_reset();
        test_immediate();
        test_factorial();
        test_in_stall();
        test_timeout();
        test_timeout_boundary();
        test_rsp_backpressure();
        test_reset_mid_call();
        test_random();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
